// File: rtl/voice_frame_sequencer_if.sv
// Bus bundle between the frame sequencer and its datapath/host surroundings.
// The master side is the sequencer. The slave side is the datapath, host and
// timing logic that drive ticks, masks and done handshakes.
interface voice_frame_sequencer_if #(
    parameter int NUM_VOICES = 3
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    // frame control
    logic                  enable;
    logic                  sample_tick;
    logic [NUM_VOICES-1:0] voice_mask;

    // datapath sequencing
    logic [VW-1:0]         voice_idx;
    logic                  rf_rd_en;
    logic                  osc_en;
    logic                  mul_start;
    logic                  mul_done;
    logic                  mix_clr;
    logic                  mix_en;
    logic                  filt_start;
    logic                  filt_done;
    logic                  sample_valid;

    // status
    logic                  busy;
    logic                  overrun;
    logic                  overrun_clr;

    // register-file port arbitration
    logic                  host_wr_req;
    logic                  host_wr_gnt;

    modport master (
        input  enable, sample_tick, voice_mask, mul_done, filt_done,
               overrun_clr, host_wr_req,
        output voice_idx, rf_rd_en, osc_en, mul_start, mix_clr, mix_en,
               filt_start, sample_valid, busy, overrun, host_wr_gnt
    );

    modport slave (
        output enable, sample_tick, voice_mask, mul_done, filt_done,
               overrun_clr, host_wr_req,
        input  voice_idx, rf_rd_en, osc_en, mul_start, mix_clr, mix_en,
               filt_start, sample_valid, busy, overrun, host_wr_gnt
    );
endinterface

// File: rtl/voice_frame_sequencer.sv
// Per-sample frame scheduler. On each accepted tick it clears the mixer and
// walks every enabled voice through fetch/osc/env/mix. It then runs the
// shared filter once and strobes the finished sample. It also gives the host
// the register-file port in every cycle except the sequencer's fetch cycle.
module voice_frame_sequencer #(
    parameter int NUM_VOICES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    voice_frame_sequencer_if.master  bus
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [3:0] {
        IDLE,
        CLR,
        FETCH,
        OSC,
        ENV,
        ENV_WAIT,
        MIX,
        FILT,
        FILT_WAIT,
        OUT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [VW-1:0] voice_idx;
    logic [VW-1:0] sel_idx;
    logic          sel_found;
    logic          busy;
    logic          overrun;

    assign busy = (state != IDLE);

    // Pick the next enabled voice: the lowest one from CLR, otherwise the
    // lowest one strictly above the current voice. Because the search only
    // moves upward, the frame terminates even if the mask changes mid-frame.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!sel_found && bus.voice_mask[i] &&
                ((state == CLR) || (i > int'(voice_idx)))) begin
                sel_found = 1'b1;
                sel_idx   = VW'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and Moore strobe decode, one strobe per state
    always_comb begin
        state_nxt        = state;
        bus.rf_rd_en     = 1'b0;
        bus.osc_en       = 1'b0;
        bus.mul_start    = 1'b0;
        bus.mix_clr      = 1'b0;
        bus.mix_en       = 1'b0;
        bus.filt_start   = 1'b0;
        bus.sample_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.sample_tick && bus.enable) state_nxt = CLR;
            end
            CLR: begin
                bus.mix_clr = 1'b1;
                state_nxt   = sel_found ? FETCH : FILT;
            end
            FETCH: begin
                bus.rf_rd_en = 1'b1;
                state_nxt    = OSC;
            end
            OSC: begin
                bus.osc_en = 1'b1;
                state_nxt  = ENV;
            end
            ENV: begin
                bus.mul_start = 1'b1;
                state_nxt     = ENV_WAIT;
            end
            ENV_WAIT: begin
                if (bus.mul_done) state_nxt = MIX;
            end
            MIX: begin
                bus.mix_en = 1'b1;
                state_nxt  = sel_found ? FETCH : FILT;
            end
            FILT: begin
                bus.filt_start = 1'b1;
                state_nxt      = FILT_WAIT;
            end
            FILT_WAIT: begin
                if (bus.filt_done) state_nxt = OUT;
            end
            OUT: begin
                bus.sample_valid = 1'b1;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Voice index is loaded when a voice is entered and held through its MIX.
    // It returns to zero when the frame ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     voice_idx <= '0;
        else if (state_nxt == FETCH) voice_idx <= sel_idx;
        else if (state_nxt == IDLE)  voice_idx <= '0;
    end

    // Sticky overrun: a tick while busy is dropped and flagged. A same-cycle
    // set takes priority over the clear so that no event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          overrun <= 1'b0;
        else if (bus.sample_tick && busy) overrun <= 1'b1;
        else if (bus.overrun_clr)         overrun <= 1'b0;
    end

    // The host owns the register-file port in every cycle except FETCH.
    // The grant is held low while in reset.
    always_comb begin
        bus.host_wr_gnt = bus.host_wr_req && !rst && (state != FETCH);
    end

    // Status outputs
    always_comb begin
        bus.voice_idx = voice_idx;
        bus.busy      = busy;
        bus.overrun   = overrun;
    end

endmodule

// File: tb/tb_voice_frame_sequencer.sv
// Frame-level bench for voice_frame_sequencer. Each scenario builds the strobe
// sequence it expects into a scoreboard queue. Strobes seen on the DUT are
// popped and compared by cycle, kind and voice.
module tb_voice_frame_sequencer;
    localparam logic [6:0] S_RF   = 7'h01;
    localparam logic [6:0] S_OSC  = 7'h02;
    localparam logic [6:0] S_MUL  = 7'h04;
    localparam logic [6:0] S_CLR  = 7'h08;
    localparam logic [6:0] S_MIX  = 7'h10;
    localparam logic [6:0] S_FILT = 7'h20;
    localparam logic [6:0] S_OUT  = 7'h40;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
        logic [1:0] vidx;
        bit         chk_v;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    voice_frame_sequencer_if #(.NUM_VOICES(3)) bus ();

    voice_frame_sequencer #(.NUM_VOICES(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    ev_t exp_q[$];
    bit  fetch_at[128];
    int  mdel[3];
    int  t2_cyc, clr_cyc, en_off_cyc, rst_cyc;
    int  n_chk  = 0;
    int  n_pass = 0;

    function automatic logic [6:0] obs_vec();
        return {bus.sample_valid, bus.filt_start, bus.mix_en, bus.mix_clr,
                bus.mul_start, bus.osc_en, bus.rf_rd_en};
    endfunction

    function automatic void push_ev(int c, logic [6:0] v, logic [1:0] vi, bit cv);
        ev_t e;
        e.cyc = c; e.vec = v; e.vidx = vi; e.chk_v = cv;
        exp_q.push_back(e);
    endfunction

    // Expected frame with the tick in cycle 0. Each voice occupies FETCH, OSC,
    // ENV, mdel wait cycles and MIX. The filter done comes one cycle after
    // its start.
    function automatic void build(logic [2:0] mask);
        int c;
        foreach (fetch_at[i]) fetch_at[i] = 1'b0;
        push_ev(1, S_CLR, 2'd0, 1'b1);
        c = 2;
        for (int v = 0; v < 3; v++) begin
            if (mask[v]) begin
                fetch_at[c] = 1'b1;
                push_ev(c,     S_RF,  2'(v), 1'b1);
                push_ev(c + 1, S_OSC, 2'(v), 1'b1);
                push_ev(c + 2, S_MUL, 2'(v), 1'b1);
                push_ev(c + 3 + mdel[v], S_MIX, 2'(v), 1'b1);
                c = c + 4 + mdel[v];
            end
        end
        push_ev(c,     S_FILT, 2'd0, 1'b0);
        push_ev(c + 2, S_OUT,  2'd0, 1'b0);
    endfunction

    task automatic clear_knobs();
        t2_cyc = -1; clr_cyc = -1; en_off_cyc = -1; rst_cyc = -1;
        mdel[0] = 1; mdel[1] = 1; mdel[2] = 1;
    endtask

    // Runs one frame from a tick in cycle 0. It answers mul/filt starts with
    // the configured latency and checks strobes against the scoreboard. It
    // then requires an idle, strobe-free window afterwards.
    task automatic run_frame(input string tag, input logic [2:0] mask);
        int         ms, fs, cd, done_k, bad;
        bit         aborted;
        logic [6:0] v;
        ev_t        e;
        ms = -1; fs = -1; cd = 1; done_k = -1; aborted = 1'b0;
        bus.voice_mask = mask;
        build(mask);
        for (int k = 0; k < 80 && done_k < 0 && !aborted; k++) begin
            @(posedge clk); #1;
            bus.sample_tick = (k == 0) || (k == t2_cyc);
            bus.overrun_clr = (k == clr_cyc);
            if (k == en_off_cyc) bus.enable = 1'b0;
            bus.mul_done  = (ms >= 0) && (k - ms >= cd);
            bus.filt_done = (fs >= 0) && (k - fs >= 1);
            if (k == rst_cyc) rst = 1'b1;
            @(negedge clk);
            v = obs_vec();
            if (k == rst_cyc) begin
                n_chk++;
                if ({v, bus.busy, bus.overrun, bus.host_wr_gnt, bus.voice_idx} !== 12'h0)
                    $display("FAIL %s rst_outputs: got strobes=%b busy=%b ovr=%b gnt=%b vidx=%0d, want all 0",
                             tag, v, bus.busy, bus.overrun, bus.host_wr_gnt, bus.voice_idx);
                else n_pass++;
                exp_q.delete();
                aborted = 1'b1;
            end else begin
                if (bus.host_wr_req) begin
                    n_chk++;
                    if (bus.host_wr_gnt !== !fetch_at[k])
                        $display("FAIL %s gnt cyc %0d: got %b want %b", tag, k, bus.host_wr_gnt, !fetch_at[k]);
                    else n_pass++;
                end
                if (v != 7'h0) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL %s extra_strobe cyc %0d: got %b want none", tag, k, v);
                    end else begin
                        e = exp_q.pop_front();
                        if (k !== e.cyc || v !== e.vec || (e.chk_v && bus.voice_idx !== e.vidx))
                            $display("FAIL %s strobe: got cyc %0d vec %b vidx %0d, want cyc %0d vec %b vidx %0d",
                                     tag, k, v, bus.voice_idx, e.cyc, e.vec, e.vidx);
                        else n_pass++;
                    end
                    if (v[2]) begin ms = k; cd = mdel[bus.voice_idx]; end
                    if (v[4]) ms = -1;
                    if (v[5]) fs = k;
                    if (v[6]) done_k = k;
                end
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.sample_tick = 1'b0; bus.overrun_clr = 1'b0;
        bus.mul_done = 1'b0; bus.filt_done = 1'b0;
        n_chk++;
        if (!aborted && done_k < 0) $display("FAIL %s timeout: got no sample_valid, want one", tag);
        else n_pass++;
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL %s missing: got %0d unseen strobes, want 0", tag, exp_q.size());
        else n_pass++;
        exp_q.delete();
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (obs_vec() != 7'h0 || bus.busy !== 1'b0) bad++;
        end
        n_chk++;
        if (bad != 0) $display("FAIL %s idle_after: got %0d active cycles, want 0", tag, bad);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.enable = 1'b1; bus.sample_tick = 1'b0; bus.voice_mask = 3'b111;
        bus.mul_done = 1'b0; bus.filt_done = 1'b0; bus.overrun_clr = 1'b0;
        bus.host_wr_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({obs_vec(), bus.busy, bus.overrun, bus.host_wr_gnt, bus.voice_idx} !== 12'h0)
            $display("FAIL reset_state: got strobes=%b busy=%b ovr=%b gnt=%b vidx=%0d, want all 0",
                     obs_vec(), bus.busy, bus.overrun, bus.host_wr_gnt, bus.voice_idx);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.host_wr_gnt !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL idle_grant: got gnt=%b busy=%b, want gnt=1 busy=0", bus.host_wr_gnt, bus.busy);
        else n_pass++;
        bus.host_wr_req = 1'b0;
    endtask

    task automatic test_all_voices();
        clear_knobs();
        run_frame("all_voices", 3'b111);
    endtask

    task automatic test_sparse_mask();
        clear_knobs();
        run_frame("mask_101", 3'b101);
        clear_knobs();
        run_frame("mask_000", 3'b000);
    endtask

    task automatic test_mul_delay();
        clear_knobs();
        mdel[1] = 4;
        run_frame("mul_delay", 3'b111);
    endtask

    task automatic test_overrun();
        clear_knobs();
        t2_cyc = 10;
        run_frame("overrun_set", 3'b111);
        n_chk++;
        if (bus.overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", bus.overrun);
        else n_pass++;
        clear_knobs();
        t2_cyc = 10; clr_cyc = 10;
        run_frame("overrun_both", 3'b011);
        n_chk++;
        if (bus.overrun !== 1'b1) $display("FAIL overrun_set_wins: got %b want 1", bus.overrun);
        else n_pass++;
        @(posedge clk); #1;
        bus.overrun_clr = 1'b1;
        @(posedge clk); #1;
        bus.overrun_clr = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.overrun !== 1'b0) $display("FAIL overrun_clr: got %b want 0", bus.overrun);
        else n_pass++;
    endtask

    task automatic test_enable();
        int act;
        clear_knobs();
        bus.enable = 1'b1;
        en_off_cyc = 5;
        run_frame("enable_off_midframe", 3'b111);
        act = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            bus.sample_tick = (k == 1);
            @(negedge clk);
            if (obs_vec() != 7'h0 || bus.busy !== 1'b0) act++;
        end
        bus.sample_tick = 1'b0;
        n_chk++;
        if (act != 0 || bus.overrun !== 1'b0)
            $display("FAIL disabled_tick: got active=%0d ovr=%b, want 0 and 0", act, bus.overrun);
        else n_pass++;
        bus.enable = 1'b1;
    endtask

    task automatic test_arbitration();
        clear_knobs();
        bus.host_wr_req = 1'b1;
        run_frame("arbitration", 3'b111);
        bus.host_wr_req = 1'b0;
    endtask

    task automatic test_reset_midframe();
        clear_knobs();
        mdel[1] = 99;
        rst_cyc = 12;
        bus.host_wr_req = 1'b1;
        run_frame("rst_env_wait", 3'b111);
        bus.host_wr_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_all_voices();
        test_sparse_mask();
        test_mul_delay();
        test_overrun();
        test_enable();
        test_arbitration();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/voice_frame_sequencer.md
Name: voice_frame_sequencer

Overview:
- Per-sample scheduler for the TT6581 synthesis core.
- On each audio sample tick it walks the enabled voices through the shared datapath: register-file fetch, phase accumulator, shared envelope multiplier, mixer accumulate.
- It then runs the shared filter once and strobes the finished sample to the output stage.
- It also arbitrates register-file access between the sequencer and host writes arriving from the SPI interface.

Parameters:
- NUM_VOICES, 3, number of time-multiplexed voices (voice_idx width = 2 at default).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  sequencer enable; ticks ignored while low
- sample_tick  input  1  one-cycle strobe, start of a sample frame
- voice_mask  input  NUM_VOICES  bit i = 1 enables voice i
- voice_idx  output  2  voice currently addressed by the datapath
- rf_rd_en  output  1  register-file read for voice_idx
- osc_en  output  1  advance phase accumulator of voice_idx
- mul_start  output  1  one-cycle start to the shared envelope multiplier
- mul_done  input  1  multiplier result valid
- mix_clr  output  1  clear mixer accumulator
- mix_en  output  1  add voice_idx product into mixer
- filt_start  output  1  one-cycle start to the shared filter
- filt_done  input  1  filter result valid
- sample_valid  output  1  one-cycle strobe, output sample ready
- busy  output  1  high whenever the FSM is not in IDLE
- overrun  output  1  sticky: tick arrived while busy
- overrun_clr  input  1  clears overrun
- host_wr_req  input  1  host register write pending (held until granted)
- host_wr_gnt  output  1  host write may use register-file port this cycle

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE.
  - voice_idx=0; all strobes, busy, overrun and host_wr_gnt are 0.
  - Reset mid-frame aborts the frame with no sample_valid.
- All strobes are Moore outputs decoded from the registered state; each is high only in its own state.
- States:
  - IDLE: sample_tick & enable -> CLR.
  - CLR: mix_clr=1. Go to FETCH at the lowest enabled voice; if voice_mask==0, go to FILT.
  - FETCH: rf_rd_en=1 -> OSC.
  - OSC: osc_en=1 -> ENV.
  - ENV: mul_start=1 -> ENV_WAIT.
  - ENV_WAIT: stay until mul_done=1 -> MIX. mul_done is sampled only in ENV_WAIT.
  - MIX: mix_en=1. Go to FETCH at the next higher enabled voice, else FILT.
  - FILT: filt_start=1 -> FILT_WAIT.
  - FILT_WAIT: stay until filt_done=1 -> OUT. filt_done is sampled only in FILT_WAIT.
  - OUT: sample_valid=1 -> IDLE.
- Disabled voices are skipped entirely: no strobes are issued and voice_idx never takes their index.
- voice_idx is loaded on entry to FETCH and held through MIX; it returns to 0 in IDLE.
- Timing, with zero-wait handshakes (done high on the first wait cycle) and tick in cycle 0:
  - mix_clr in cycle 1.
  - Each enabled voice takes 5 cycles.
  - sample_valid in cycle 1 + 5·N + 3 (cycle 19 with all 3 voices enabled).
- Overrun:
  - sample_tick while busy (enable irrelevant) is dropped and sets overrun.
  - overrun_clr clears it; simultaneous set and clear -> set wins.
- enable deasserted mid-frame: the current frame completes normally; later ticks are ignored and do not set overrun.
- Arbitration: host_wr_gnt = host_wr_req & (state != FETCH), combinational.
  - The sequencer always wins the FETCH cycle.
  - The host is granted in every other cycle, including IDLE.
- voice_mask is sampled at each voice-selection decision (CLR, MIX); the host must not change it mid-frame. Behaviour on a mid-frame change is defined only as: the frame still terminates.

Test Plan:
- Reset, then tick with mask=3'b111 and mul_done/filt_done tied high:
  - mix_clr at cycle 1.
  - voice_idx sequence 0,1,2; three pulses each of rf_rd_en, osc_en, mul_start, mix_en.
  - sample_valid at cycle 19; busy=0 at cycle 20.
- mask=3'b101: voice_idx visits only 0 and 2; sample_valid at cycle 14.
- mask=3'b000: mix_clr at cycle 1, filt_start at cycle 2, sample_valid at cycle 4.
- mul_done delayed 4 cycles for voice 1: FSM holds in ENV_WAIT with voice_idx=1 and no mix_en until mul_done; sample_valid at cycle 22.
- Overrun and clear:
  - Second tick at cycle 10 -> overrun=1, frame unaffected, no second frame starts.
  - overrun_clr and a new busy tick in the same cycle -> overrun stays 1.
  - overrun_clr alone -> overrun=0.
- Arbitration and reset:
  - host_wr_req held high during a frame -> host_wr_gnt low exactly in the three FETCH cycles, high otherwise.
  - rst asserted in ENV_WAIT -> all outputs 0 immediately; no sample_valid afterwards.
